mor1kx_divider_marocchino: RTL
==============================

Name: mor1kx_divider_marocchino

Overview:
- Serial restoring integer divider for the MAROCCHINO execute stage; one quotient bit per clock.
- Implements l.div and l.divu.
- Feeds the RF writeback mux: registered result, ready strobe and carry/overflow set/clear, all aligned to padv_wb_i.
- Asserts a not-ready indication so pipeline control stalls until the quotient is available.

Parameters:
- OPTION_OPERAND_WIDTH, 32, operand/quotient width W; must be even and >= 8.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- padv_exec_i  in  1  execute-stage advance; start qualifier.
- padv_wb_i  in  1  writeback advance; consumes a completed result.
- pipeline_flush_i  in  1  abort any operation, clear outputs.
- exec_op_div_signed_i  in  1  l.div issued this cycle.
- exec_op_div_unsigned_i  in  1  l.divu issued this cycle.
- exec_opa_i  in  W  dividend.
- exec_opb_i  in  W  divisor.
- div_valid_o  out  1  quotient computed, awaiting padv_wb_i.
- div_busy_o  out  1  operation in progress (not IDLE, not DONE).
- wb_div_rdy_o  out  1  result present at writeback this cycle.
- wb_div_result_o  out  W  quotient for the writeback mux.
- wb_div_carry_set_o, wb_div_carry_clear_o  out  1 each  SR[CY] update.
- wb_div_overflow_set_o, wb_div_overflow_clear_o  out  1 each  SR[OV] update.

Behaviour:
- Reset (sync): state IDLE, counter 0, all outputs 0, wb_div_result_o 0.
- start = padv_exec_i & (exec_op_div_signed_i | exec_op_div_unsigned_i) & ~pipeline_flush_i. Accepted in IDLE, or in DONE when padv_wb_i is high in the same cycle. Ignored in any other state; upstream guarantees it is not issued then.
- FSM IDLE -> CALC -> FIX -> DONE -> IDLE/CALC.
- On start:
  - Latch signedness.
  - Signed: operands converted to magnitudes; result sign = a[W-1] ^ b[W-1].
  - Latch dbz = (opb == 0).
  - Remainder cleared; counter = W-1; go to CALC.
- CALC, each cycle:
  - Form the (W+1)-bit trial {rem[W-1:0], dividend_msb} - divisor.
  - If non-negative: rem <= trial and quotient bit = 1; otherwise quotient bit = 0.
  - Dividend shifts left by 1.
  - Counter decrements; at 0 go to FIX.
- FIX (1 cycle):
  - Negate the quotient if signed and result sign = 1.
  - Force quotient to 0 if dbz.
  - Go to DONE.
- DONE: div_valid_o = 1.
  - padv_wb_i -> next cycle wb_div_rdy_o = 1, and wb_div_result_o, flags loaded.
  - Then IDLE, or CALC if a new start was accepted in the same cycle.
- Latency: start at cycle T -> div_valid_o high from T+W+2 (W=32: T+34).
- wb_div_rdy_o is a 1-cycle pulse per padv_wb_i consuming a valid result. wb_div_result_o holds until the next load.
- Flags, loaded with the result:
  - Signed: overflow_set = dbz, overflow_clear = ~dbz; carry set/clear = 0.
  - Unsigned: carry_set = dbz, carry_clear = ~dbz; overflow set/clear = 0.
- Signed most-negative / -1: result 0x80000000 (W=32), no flags.
- pipeline_flush_i in any state:
  - Next state IDLE.
  - div_valid_o, wb_div_rdy_o and all flag outputs cleared next cycle.
  - wb_div_result_o keeps its value.
  - Flush has priority over start and padv_wb_i.
- padv_wb_i while not DONE: wb_div_rdy_o = 0 and flag outputs cleared next cycle.
- div_busy_o = (state == CALC) | (state == FIX).

Optional Feature:
- Macro MOR1KX_DIV_MAROCCHINO_EARLY_DONE_EN.
- Defined: on start, if dbz or |a| < |b| (magnitudes), skip CALC.
  - Quotient forced to 0; next state FIX.
  - div_valid_o high at T+2.
  - Flags as above.
- Undefined: every division takes the full W-cycle CALC; no magnitude comparator is built.

Test Plan:
- l.divu 100/7, W=32 -> div_valid_o at T+34; padv_wb_i -> wb_div_rdy_o pulse, result 0x0000000E, carry_clear=1, carry_set=0.
- l.div 0xFFFFFF9C/7 -> result 0xFFFFFFF2, overflow_clear=1; 0x80000000/0xFFFFFFFF -> 0x80000000, overflow_set=0.
- l.div 5/0 -> result 0, overflow_set=1; l.divu 5/0 -> result 0, carry_set=1. With EARLY_DONE_EN, valid at T+2.
- Flush at T+10 mid-CALC -> IDLE next cycle, div_valid_o stays 0, no wb_div_rdy_o pulse; a new start at T+12 produces a correct result.
- Back-to-back: second start in the same cycle as padv_wb_i in DONE -> wb_div_rdy_o for the first result; second result valid 34 cycles later.
- rst asserted mid-CALC -> all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/mor1kx_divider_marocchino.sv
// Serial restoring divider (l.div / l.divu), one quotient bit per clock, results aligned to padv_wb_i.
// Optional: define MOR1KX_DIV_MAROCCHINO_EARLY_DONE_EN to bypass CALC for divide-by-zero or |a| < |b|.
module mor1kx_divider_marocchino #(
    parameter int OPTION_OPERAND_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            padv_exec_i,
    input  logic                            padv_wb_i,
    input  logic                            pipeline_flush_i,
    input  logic                            exec_op_div_signed_i,
    input  logic                            exec_op_div_unsigned_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] exec_opa_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] exec_opb_i,
    output logic                            div_valid_o,
    output logic                            div_busy_o,
    output logic                            wb_div_rdy_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wb_div_result_o,
    output logic                            wb_div_carry_set_o,
    output logic                            wb_div_carry_clear_o,
    output logic                            wb_div_overflow_set_o,
    output logic                            wb_div_overflow_clear_o
);
    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic [W-1:0]  dvd_reg;     // dividend; quotient bits shift in at the LSB
    logic [W-1:0]  dvs_reg;
    logic [W-1:0]  rem_reg;
    logic          signed_reg;
    logic          neg_reg;
    logic          dbz_reg;
    logic          valid_reg;
    logic          rdy_reg;
    logic [W-1:0]  result_reg;
    logic          cy_set_reg;
    logic          cy_clr_reg;
    logic          ov_set_reg;
    logic          ov_clr_reg;

    logic          start;
    logic          accept;
    logic          opb_zero;
    logic          early;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic [W:0]    trial;
    logic          q_bit;
    logic [W-1:0]  quot_fixed;

    assign start    = padv_exec_i & (exec_op_div_signed_i | exec_op_div_unsigned_i) & ~pipeline_flush_i;
    assign accept   = start & ((state_reg == IDLE) | ((state_reg == DONE) & padv_wb_i));
    assign abs_a    = (exec_op_div_signed_i & exec_opa_i[W-1]) ? (~exec_opa_i + W'(1)) : exec_opa_i;
    assign abs_b    = (exec_op_div_signed_i & exec_opb_i[W-1]) ? (~exec_opb_i + W'(1)) : exec_opb_i;
    assign opb_zero = (exec_opb_i == '0);

`ifdef MOR1KX_DIV_MAROCCHINO_EARLY_DONE_EN
    assign early = opb_zero | (abs_a < abs_b);
`else
    assign early = 1'b0;
`endif

    assign trial      = {rem_reg, dvd_reg[W-1]} - {1'b0, dvs_reg};
    assign q_bit      = ~trial[W];
    assign quot_fixed = dbz_reg ? '0 : (neg_reg ? (~dvd_reg + W'(1)) : dvd_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            dvd_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            signed_reg <= 1'b0;
            neg_reg    <= 1'b0;
            dbz_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            rdy_reg    <= 1'b0;
            result_reg <= '0;
            cy_set_reg <= 1'b0;
            cy_clr_reg <= 1'b0;
            ov_set_reg <= 1'b0;
            ov_clr_reg <= 1'b0;
        end else begin
            rdy_reg <= 1'b0;
            if (pipeline_flush_i) begin
                state_reg  <= IDLE;
                valid_reg  <= 1'b0;
                cy_set_reg <= 1'b0;
                cy_clr_reg <= 1'b0;
                ov_set_reg <= 1'b0;
                ov_clr_reg <= 1'b0;
            end else begin
                // Writeback either consumes the finished quotient or just clears stale flags.
                if (padv_wb_i) begin
                    if (state_reg == DONE) begin
                        rdy_reg    <= 1'b1;
                        valid_reg  <= 1'b0;
                        result_reg <= dvd_reg;
                        cy_set_reg <= ~signed_reg & dbz_reg;
                        cy_clr_reg <= ~signed_reg & ~dbz_reg;
                        ov_set_reg <= signed_reg & dbz_reg;
                        ov_clr_reg <= signed_reg & ~dbz_reg;
                        state_reg  <= IDLE;
                    end else begin
                        cy_set_reg <= 1'b0;
                        cy_clr_reg <= 1'b0;
                        ov_set_reg <= 1'b0;
                        ov_clr_reg <= 1'b0;
                    end
                end

                case (state_reg)
                    CALC: begin
                        rem_reg <= q_bit ? trial[W-1:0] : {rem_reg[W-2:0], dvd_reg[W-1]};
                        dvd_reg <= {dvd_reg[W-2:0], q_bit};
                        cnt_reg <= cnt_reg - CW'(1);
                        if (cnt_reg == '0)
                            state_reg <= FIX;
                    end
                    FIX: begin
                        dvd_reg   <= quot_fixed;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                    default: ;
                endcase

                // Placed last so a start accepted in DONE overrides the return to IDLE.
                if (accept) begin
                    signed_reg <= exec_op_div_signed_i;
                    neg_reg    <= exec_op_div_signed_i & (exec_opa_i[W-1] ^ exec_opb_i[W-1]);
                    dbz_reg    <= opb_zero;
                    dvs_reg    <= abs_b;
                    rem_reg    <= '0;
                    cnt_reg    <= CW'(W - 1);
                    if (early) begin
                        dvd_reg   <= '0;
                        state_reg <= FIX;
                    end else begin
                        dvd_reg   <= abs_a;
                        state_reg <= CALC;
                    end
                end
            end
        end
    end

    assign div_valid_o             = valid_reg;
    assign div_busy_o              = (state_reg == CALC) | (state_reg == FIX);
    assign wb_div_rdy_o            = rdy_reg;
    assign wb_div_result_o         = result_reg;
    assign wb_div_carry_set_o      = cy_set_reg;
    assign wb_div_carry_clear_o    = cy_clr_reg;
    assign wb_div_overflow_set_o   = ov_set_reg;
    assign wb_div_overflow_clear_o = ov_clr_reg;

endmodule
